// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its pointer counters.
// The top and the pointer sub-module take their parameter defaults from here.
package fifo_pkg;

  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_PTR_WIDTH = 4;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: PTR_WIDTH index plus a toggle bit that flips on each wrap.
// Index and toggle form one counter, so the carry out of the index is the toggle.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  output logic [PTR_WIDTH-1:0] o_idx,
  output logic                 o_tog
);

  logic [PTR_WIDTH:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + (PTR_WIDTH+1)'(1);
    end
  end

  assign o_idx = r_ptr[PTR_WIDTH-1:0];
  assign o_tog = r_ptr[PTR_WIDTH];

endmodule : fifo_ptr

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered over/underflow flags.
// Full/empty come straight from the pointer registers (index match, toggle compare).
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_error,
  output logic             rd_error,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [PTR_WIDTH-1:0] w_wr_idx;
  logic [PTR_WIDTH-1:0] w_rd_idx;
  logic                 w_wr_tog;
  logic                 w_rd_tog;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_rd_data;
  logic                 r_wr_error;
  logic                 r_rd_error;

  assign w_full   = (w_wr_idx == w_rd_idx) && (w_wr_tog != w_rd_tog);
  assign w_empty  = (w_wr_idx == w_rd_idx) && (w_wr_tog == w_rd_tog);
  // Both requests are judged on the pre-edge flags, so a simultaneous
  // read/write when empty or full accepts only one side.
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_acc),
    .o_idx (w_wr_idx),
    .o_tog (w_wr_tog)
  );

  fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_acc),
    .o_idx (w_rd_idx),
    .o_tog (w_rd_tog)
  );

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_wr_error <= 1'b0;
      r_rd_error <= 1'b0;
    end else begin
      r_wr_error <= wr_en && w_full;
      r_rd_error <= rd_en && w_empty;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[w_rd_idx];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign wr_error = r_wr_error;
  assign rd_error = r_rd_error;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule : fifo

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: each stimulus cycle queues its hand-computed
// expected outputs, and a monitor compares them one time unit after the edge.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       wr_error;
  logic       rd_error;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;

  int checks;
  int errors;

  typedef struct {
    int         tag;
    logic [7:0] rd_data;
    logic       werr;
    logic       rerr;
    logic       full;
    logic       empty;
  } exp_t;

  exp_t exp_q[$];

  fifo #(.DEPTH(16), .WIDTH(8), .PTR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wr_error (wr_error),
    .rd_error (rd_error),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%0h expected=%0h", name, tag, act, exp);
    end
  endtask

  // Monitor: one comparison set and one line per queued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", e.tag, 32'(rd_data), 32'(e.rd_data));
        chk("wr_error", e.tag, 32'(wr_error), 32'(e.werr));
        chk("rd_error", e.tag, 32'(rd_error), 32'(e.rerr));
        chk("full", e.tag, 32'(full), 32'(e.full));
        chk("empty", e.tag, 32'(empty), 32'(e.empty));
        $display("txn tag=%0d rd_data=%02h werr=%0b rerr=%0b full=%0b empty=%0b",
                 e.tag, rd_data, wr_error, rd_error, full, empty);
      end
    end
  end

  // One stimulus cycle with its expected post-edge outputs.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic [7:0] erd, input logic ewe, input logic ere,
                     input logic ef, input logic ee, input int tag);
    exp_t e;
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    e.tag = tag; e.rd_data = erd; e.werr = ewe; e.rerr = ere; e.full = ef; e.empty = ee;
    exp_q.push_back(e);
  endtask

  task automatic drain_q(input int tag);
    int n;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout tag=%0d actual=%0d pending expected=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input int tag);
    drain_q(tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_empty", tag, 32'(empty), 32'd1);
    chk("rst_full", tag, 32'(full), 32'd0);
    chk("rst_rd_data", tag, 32'(rd_data), 32'd0);
    chk("rst_wr_error", tag, 32'(wr_error), 32'd0);
    chk("rst_rd_error", tag, 32'(rd_error), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #3;
    do_reset(0);

    // 16 writes of i*2: full on the 16th, never an overflow
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 8'(i*2), 8'h00, 0, 0, (i == 15), 0, 100 + i);
    // 16 reads return 0,2,...,30 with one-cycle latency
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 8'h00, 8'(i*2), 0, 0, 0, (i == 15), 200 + i);

    do_reset(1);
    // 16 reads while empty: underflow each cycle, rd_data stays 0
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 8'h00, 8'h00, 0, 1, 0, 1, 300 + i);

    do_reset(2);
    // 20 writes: last 4 overflow and must not corrupt contents
    for (int i = 0; i < 20; i++)
      cyc(1, 0, (i < 16) ? 8'(i*2) : 8'hAA, 8'h00, (i >= 16), 0, (i >= 15), 0, 400 + i);
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 8'h00, 8'(i*2), 0, 0, 0, (i == 15), 500 + i);
    cyc(0, 0, 8'h00, 8'd30, 0, 0, 0, 1, 520);

    // 5 writes then 6 reads: one underflow cycle, rd_data holds
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 8'(8'h10 + i), 8'd30, 0, 0, 0, 0, 600 + i);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 8'h00, (i < 5) ? 8'(8'h10 + i) : 8'h14, 0, (i == 5), 0, (i >= 4), 610 + i);
    cyc(0, 0, 8'h00, 8'h14, 0, 0, 0, 1, 620);

    // write/read pairs of value 1 walk the pointers through a wrap
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'h01, (i == 0) ? 8'h14 : 8'h01, 0, 0, 0, 0, 700 + 2*i);
      cyc(0, 1, 8'h00, 8'h01, 0, 0, 0, 1, 701 + 2*i);
    end

    // simultaneous read+write: empty, mid-occupancy, then full
    cyc(1, 1, 8'h55, 8'h01, 0, 1, 0, 0, 800);
    cyc(1, 1, 8'h66, 8'h55, 0, 0, 0, 0, 801);
    for (int i = 0; i < 15; i++)
      cyc(1, 0, 8'(8'h70 + i), 8'h55, 0, 0, (i == 14), 0, 810 + i);
    cyc(1, 1, 8'hEE, 8'h66, 1, 0, 0, 0, 830);
    for (int i = 0; i < 15; i++)
      cyc(0, 1, 8'h00, 8'(8'h70 + i), 0, 0, 0, (i == 14), 840 + i);

    // reset mid-operation discards stored words
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 8'(8'hA1 + i), 8'h7E, 0, 0, 0, 0, 900 + i);
    do_reset(3);
    cyc(1, 0, 8'hB1, 8'h00, 0, 0, 0, 0, 910);
    cyc(0, 1, 8'h00, 8'hB1, 0, 0, 0, 1, 911);

    drain_q(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo
